input_matrix: RTL and testbench

INPUT_MATRIX -- requirements
Module: input_matrix

---
 rtl/input_matrix.sv | 106 ++++++++++
 tb/tb_input_matrix.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_matrix.sv
// input_matrix: synchronizes and debounces eight raw buttons, then routes each
// stable button level onto the sm510 K lines (strobed by S) or directly onto
// the active-low BA / beta lines, through a runtime-writable mapping table.
module input_matrix #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] buttons,
  input  logic       map_wr,
  input  logic [2:0] map_addr,
  input  logic [6:0] map_data,
  input  logic [7:0] output_shifter_s,
  output logic [3:0] input_k,
  output logic       input_ba,
  output logic       input_beta
);

  // Map entry layout
  localparam int DIRECT_BIT = 6;
  localparam int ENABLE_BIT = 5;

  logic [7:0]  sync_p0;
  logic [7:0]  sync_p1;
  logic [7:0]  stable_p2;
  logic [15:0] cnt_p2 [8];
  logic [6:0]  map_tbl [8];

  logic [3:0]  k_nxt;
  logic        ba_nxt;
  logic        beta_nxt;

  // Stage p0/p1: two-flop synchronizer on the raw asynchronous button levels
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= buttons;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-button debounce; stable follows sync only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles (zero means follow at once)
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_p2 <= '0;
      for (int i = 0; i < 8; i++) cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (DEBOUNCE_CYCLES == 16'd0) begin
          stable_p2[i] <= sync_p1[i];
          cnt_p2[i]    <= '0;
        end else if (sync_p1[i] == stable_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if ((cnt_p2[i] + 16'd1) == DEBOUNCE_CYCLES) begin
          stable_p2[i] <= sync_p1[i];
          cnt_p2[i]    <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + 16'd1;
        end
      end
    end
  end

  // Mapping table write port; reset clears every entry and wins over a write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) map_tbl[i] <= '0;
    end else if (map_wr) begin
      map_tbl[map_addr] <= map_data;
    end
  end

  // Wired-OR routing of every enabled, pressed button onto K / BA / beta
  always_comb begin
    k_nxt    = '0;
    ba_nxt   = 1'b1;
    beta_nxt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (map_tbl[i][ENABLE_BIT] && stable_p2[i]) begin
        if (map_tbl[i][DIRECT_BIT]) begin
          if (map_tbl[i][1:0] == 2'd0) ba_nxt   = 1'b0;
          else                         beta_nxt = 1'b0;
        end else if (output_shifter_s[map_tbl[i][4:2]]) begin
          k_nxt[map_tbl[i][1:0]] = 1'b1;
        end
      end
    end
  end

  // Stage p3: registered outputs toward the core
  always_ff @(posedge clk) begin
    if (reset) begin
      input_k    <= '0;
      input_ba   <= 1'b1;
      input_beta <= 1'b1;
    end else begin
      input_k    <= k_nxt;
      input_ba   <= ba_nxt;
      input_beta <= beta_nxt;
    end
  end

endmodule

// File: tb/tb_input_matrix.sv
// Testbench for input_matrix: two instances (debounce 4 and debounce 0) share
// stimulus; a behavioural model predicts both every cycle, and directed
// scenarios pin specific hand-computed values.
module tb_input_matrix;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] buttons;
  logic       map_wr;
  logic [2:0] map_addr;
  logic [6:0] map_data;
  logic [7:0] output_shifter_s;
  logic [3:0] k4, k0;
  logic       ba4, ba0, beta4, beta0;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  always #5 clk = ~clk;

  input_matrix #(.DEBOUNCE_CYCLES(16'd4)) u4 (
    .clk(clk), .reset(reset), .buttons(buttons), .map_wr(map_wr),
    .map_addr(map_addr), .map_data(map_data), .output_shifter_s(output_shifter_s),
    .input_k(k4), .input_ba(ba4), .input_beta(beta4));

  input_matrix #(.DEBOUNCE_CYCLES(16'd0)) u0 (
    .clk(clk), .reset(reset), .buttons(buttons), .map_wr(map_wr),
    .map_addr(map_addr), .map_data(map_data), .output_shifter_s(output_shifter_s),
    .input_k(k0), .input_ba(ba0), .input_beta(beta0));

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: raw samples two edges deep, a debounced level per button,
  // a count of consecutive cycles the synchronized level disagreed, the table.
  bit [7:0] m_s1 [2];
  bit [7:0] m_s2 [2];
  bit [7:0] m_st [2];
  int       m_run [2][8];
  bit [6:0] m_map [2][8];
  bit [3:0] e_k [2];
  bit       e_ba [2];
  bit       e_beta [2];

  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      int lim;
      bit [3:0] k;
      bit ba, beta;
      lim = (n == 0) ? 4 : 0;
      k = 0; ba = 1; beta = 1;
      for (int e = 0; e < 8; e++) begin
        bit [6:0] ent;
        ent = m_map[n][e];
        if (ent[5] && m_st[n][e]) begin
          if (ent[6]) begin
            if (ent[1:0] == 0) ba = 0; else beta = 0;
          end else if (output_shifter_s[ent[4:2]]) begin
            k[ent[1:0]] = 1;
          end
        end
      end
      if (reset) begin
        e_k[n] = 0; e_ba[n] = 1; e_beta[n] = 1;
        m_s1[n] = 0; m_s2[n] = 0; m_st[n] = 0;
        for (int e = 0; e < 8; e++) begin
          m_run[n][e] = 0;
          m_map[n][e] = 0;
        end
      end else begin
        e_k[n] = k; e_ba[n] = ba; e_beta[n] = beta;
        for (int b = 0; b < 8; b++) begin
          if (m_s2[n][b] != m_st[n][b]) begin
            m_run[n][b]++;
            if (m_run[n][b] >= lim) begin
              m_st[n][b] = m_s2[n][b];
              m_run[n][b] = 0;
            end
          end else begin
            m_run[n][b] = 0;
          end
        end
        m_s2[n] = m_s1[n];
        m_s1[n] = buttons;
        if (map_wr) m_map[n][map_addr] = map_data;
      end
    end
  end

  // Compare process: every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      check("k_db4",    k4,             e_k[0]);
      check("ba_db4",   {3'b0, ba4},    {3'b0, e_ba[0]});
      check("beta_db4", {3'b0, beta4},  {3'b0, e_beta[0]});
      check("k_db0",    k0,             e_k[1]);
      check("ba_db0",   {3'b0, ba0},    {3'b0, e_ba[1]});
      check("beta_db0", {3'b0, beta0},  {3'b0, e_beta[1]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_map(input logic [2:0] a, input logic [6:0] d);
    map_wr = 1'b1; map_addr = a; map_data = d;
    step();
    map_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; buttons = '0; map_wr = 1'b0; map_addr = '0; map_data = '0;
    output_shifter_s = '0;
    step(2);
    chk_en = 1'b1;
    check("reset_k",    k4, 4'h0);
    check("reset_ba",   {3'b0, ba4}, 4'h1);
    check("reset_beta", {3'b0, beta4}, 4'h1);
    reset = 1'b0;
    step();

    // Entry 4 -> S2/K2, press game_a with S2 strobed
    write_map(3'd4, 7'h2A);
    output_shifter_s = 8'h04;
    buttons[4] = 1'b1;
    step(3);
    check("db0_lat3", k0, 4'h0);
    step();
    check("db0_lat4", k0, 4'h4);
    step(2);
    check("db4_lat6", k4, 4'h0);
    step();
    check("db4_lat7", k4, 4'h4);
    output_shifter_s = 8'h02;
    step();
    check("wrong_strobe", k4, 4'h0);
    buttons = '0;
    output_shifter_s = 8'h00;
    step(8);

    // Two buttons ORed onto K1 from two S lines
    write_map(3'd0, 7'h25);
    write_map(3'd5, 7'h29);
    buttons = 8'h21;
    output_shifter_s = 8'h06;
    step(8);
    check("or_k1", k4, 4'h2);
    output_shifter_s = 8'h00;
    step();
    check("s_zero", k4, 4'h0);
    buttons = '0;
    step(8);

    // Glitch shorter than the debounce window never reaches stable
    output_shifter_s = 8'h02;
    buttons[0] = 1'b1;
    step(3);
    buttons[0] = 1'b0;
    step(5);
    check("glitch_a", k4, 4'h0);
    step(5);
    check("glitch_b", k4, 4'h0);

    // Direct entry on alarm drives beta low independent of S
    write_map(3'd7, 7'h61);
    output_shifter_s = 8'h00;
    buttons[7] = 1'b1;
    step(7);
    check("beta_press", {3'b0, beta4}, 4'h0);
    check("ba_idle",    {3'b0, ba4},   4'h1);
    output_shifter_s = 8'hFF;
    step();
    check("beta_any_s", {3'b0, beta4}, 4'h0);
    buttons[7] = 1'b0;
    step(7);
    check("beta_release", {3'b0, beta4}, 4'h1);
    check("ba_still",     {3'b0, ba4},   4'h1);

    // Reset mid-debounce with counter at 2 discards count and table
    write_map(3'd4, 7'h2A);
    output_shifter_s = 8'hFF;
    buttons[4] = 1'b1;
    step(4);
    reset = 1'b1;
    step();
    check("rst_k",    k4, 4'h0);
    check("rst_ba",   {3'b0, ba4}, 4'h1);
    check("rst_beta", {3'b0, beta4}, 4'h1);
    reset = 1'b0;
    step(10);
    check("tbl_cleared", k4, 4'h0);
    write_map(3'd4, 7'h2A);
    step();
    check("tbl_rewritten", k4, 4'h4);

    // Randomized traffic
    buttons = '0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) buttons[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) output_shifter_s = 8'($urandom);
      map_wr   = ($urandom_range(0, 7) == 0);
      map_addr = 3'($urandom);
      map_data = 7'($urandom) | 7'h20;
      if ($urandom_range(0, 9) == 0) map_data[5] = 1'b0;
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    map_wr = 1'b0;
    reset  = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
